// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if
//   Bundles the two handshakes of the read-side drain engine:
//   - FIFO read port: rd_en out to the FIFO; empty, almost_empty, dout,
//     rd_ack, rd_err back from it (responses arrive one cycle after rd_en).
//   - Output stream: m_valid / m_data towards the consumer, m_ready back.
//   Modports:
//     master - the drain engine (drives rd_en, m_valid, m_data)
//     slave  - the FIFO read port plus downstream consumer
interface fifo_rd_drain_if #(
  parameter int WIDTH = 8
);
  logic             rd_en;
  logic             empty;
  logic             almost_empty;
  logic [WIDTH-1:0] dout;
  logic             rd_ack;
  logic             rd_err;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output rd_en, m_valid, m_data,
    input  empty, almost_empty, dout, rd_ack, rd_err, m_ready
  );

  modport slave (
    input  rd_en, m_valid, m_data,
    output empty, almost_empty, dout, rd_ack, rd_err, m_ready
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
//   Read-domain drain engine for the async FIFO. Issues rd_en whenever the
//   FIFO has data and there is room downstream, captures dout on rd_ack one
//   cycle later, and re-presents the words on a valid/ready stream through a
//   2-entry buffer. Counts delivered words and failed reads.
// Ports:
//   rd_clk      read-domain clock (rising edge)
//   rd_rst_n    asynchronous active-low reset
//   en          run enable (level)
//   clr_err     synchronous clear of err_cnt / err_sticky
//   bus         fifo_rd_drain_if.master: FIFO read port + output stream
//   word_cnt    words accepted downstream (saturating)
//   err_cnt     failed reads (saturating)
//   err_sticky  set on any failed read until clr_err
//   busy        engine not idle or a read still in flight
module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 en,
  input  logic                 clr_err,
  fifo_rd_drain_if.master      bus,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic             rd_en_c;

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  logic             pop;
  logic             push;
  logic             rd_fail;
  logic [2:0]       committed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Slots already spoken for: words held plus the read whose data is on
  // its way back this cycle.
  assign pop       = (occ != 2'd0) && bus.m_ready;
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // A read completes in the cycle after rd_en; anything other than a clean
  // ack (ack without err) counts as a failed read and is not buffered.
  assign push    = inflight && bus.rd_ack && !bus.rd_err;
  assign rd_fail = inflight && !(bus.rd_ack && !bus.rd_err);

  // State register
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en_c;
    end
  end

  // Next state and read issue. The almost_empty term stops a second read
  // being launched at the last word while the FIFO's registered empty flag
  // has not yet caught up with the read already in flight.
  always_comb begin
    state_nxt = state;
    rd_en_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) state_nxt = STOP;
        rd_en_c = !bus.empty
               && !(bus.almost_empty && inflight)
               && (committed < (3'd2 + {2'b00, pop}));
      end
      STOP: begin
        if (en)             state_nxt = RUN;
        else if (!inflight) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_en = rd_en_c;
  assign busy      = (state != IDLE) || inflight;

  // Output buffer: 2-entry ring, head presented directly so m_data only
  // moves when the head is popped.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.dout;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = mem[rd_ptr];

  // Status counters. An error coinciding with clr_err survives the clear
  // as a single count.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      word_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (pop) word_cnt <= sat_inc(word_cnt);
      if (clr_err) begin
        err_cnt    <= rd_fail ? CNT_W'(1) : '0;
        err_sticky <= rd_fail;
      end else if (rd_fail) begin
        err_cnt    <= sat_inc(err_cnt);
        err_sticky <= 1'b1;
      end
    end
  end

  // Credit check on rd_en guarantees a free slot for every completing read.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(push && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             rd_clk = 1'b0;
  logic             rd_rst_n = 1'b1;
  logic             en = 1'b0;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;
  logic             busy;

  fifo_rd_drain_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .en         (en),
    .clr_err    (clr_err),
    .bus        (bus),
    .word_cnt   (word_cnt),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky),
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and scoreboard of words the engine must deliver, in order.
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int  exp_words = 0;
  int  exp_err = 0;
  bit  exp_sticky = 0;
  int  occ_m = 0;        // words the engine should be holding
  bit  push_pend = 0;    // clean ack presented this cycle
  bit  rd_issued = 0;    // read outstanding from the FIFO's point of view
  int  rd_pulses = 0;
  int  run_len = 0;
  int  max_run = 0;
  int  err_mode_req = 0; // one-shot: 1 rd_err, 2 no response, 3 ack+err
  bit  clr_req = 0;
  bit  clr_on_err = 0;
  bit  rst_req = 0;
  int  rst_epoch = 0;
  bit  spurious_en = 0;
  bit  refill_en = 0;
  bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of the FIFO read port and the reference model.
  task automatic step();
    bit issued_now, pop_now, rst_now, bad, err_now;
    int size_before, mode;
    @(negedge rd_clk);
    issued_now = (bus.rd_en === 1'b1);
    pop_now    = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b1);
    check("m_valid_vs_held", bus.m_valid, (occ_m != 0));
    if (issued_now) begin
      checks++;
      if (occ_m + int'(rd_issued) - int'(pop_now) >= 2) begin
        errors++;
        $display("FAIL rd_en_credit: got rd_en=1 with held %0d inflight %0d pop %0d, expected rd_en=0",
                 occ_m, rd_issued, pop_now);
      end
      rd_pulses++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    rst_now = rst_req;
    if (rst_req) begin
      #1 rd_rst_n = 1'b0;
      #1;
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_data", bus.m_data, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_err_sticky", err_sticky, 0);
      check("rst_busy", busy, 0);
      #1 rd_rst_n = 1'b1;
      rst_req = 0;
      rst_epoch++;
      exp_q.delete();
      exp_words = 0;
      exp_err = 0;
      exp_sticky = 0;
    end
    @(posedge rd_clk);
    #1;
    if (rst_now) begin
      occ_m = 0;
      push_pend = 0;
    end else begin
      occ_m = occ_m + int'(push_pend) - int'(pop_now);
    end
    bus.rd_ack = 1'b0;
    bus.rd_err = 1'b0;
    bus.dout   = WIDTH'($urandom);
    push_pend  = 0;
    bad        = 0;
    size_before = fifo_q.size();
    if (issued_now) begin
      mode = rst_now ? 0 : err_mode_req;
      if (mode != 0) err_mode_req = 0;
      checks++;
      if (size_before == 0) begin
        errors++;
        $display("FAIL fifo_underflow: got rd_en=1 with FIFO empty, expected rd_en=0");
        bus.rd_err = 1'b1;
        bad = 1;
      end else begin
        case (mode)
          1: begin bus.rd_err = 1'b1; bad = 1; end
          2: bad = 1;
          3: begin bus.rd_ack = 1'b1; bus.rd_err = 1'b1; bus.dout = fifo_q[0]; bad = 1; end
          default: begin
            bus.dout   = fifo_q.pop_front();
            bus.rd_ack = 1'b1;
            if (!rst_now) begin
              exp_q.push_back(bus.dout);
              push_pend = 1;
            end
          end
        endcase
      end
    end else if (spurious_en && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) bus.rd_ack = 1'b1;
      else                           bus.rd_err = 1'b1;
    end
    err_now = bad && !rst_now;
    if (err_now && clr_on_err) begin
      clr_req = 1;
      clr_on_err = 0;
    end
    clr_err = clr_req;
    if (clr_req) begin
      exp_err = err_now ? 1 : 0;
      exp_sticky = err_now;
      clr_req = 0;
    end else if (err_now) begin
      exp_err++;
      exp_sticky = 1;
    end
    rd_issued = issued_now && !rst_now;
    // Flags are registered in the FIFO: they show the count before this
    // edge's read took effect.
    bus.empty        = (size_before == 0);
    bus.almost_empty = (size_before <= 1);
    if (refill_en && fifo_q.size() < 12 && $urandom_range(0, 1) == 1)
      fifo_q.push_back(WIDTH'($urandom));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && occ_m == 0 && !rd_issued) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending after %0d cycles, expected 0",
               exp_q.size() + fifo_q.size(), limit);
    end
  endtask

  // Monitor: every accepted word is compared with the scoreboard head, and
  // a stalled word must hold.
  bit               mon_prev_stall = 0;
  logic [WIDTH-1:0] mon_prev_data = '0;
  int               mon_prev_epoch = 0;
  initial begin
    forever begin
      @(negedge rd_clk);
      if (rd_rst_n === 1'b1) begin
        if (mon_prev_stall && mon_prev_epoch == rst_epoch) begin
          check("stall_valid_hold", bus.m_valid, 1);
          check("stall_data_hold", bus.m_data, mon_prev_data);
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h, expected no output", bus.m_data);
          end else begin
            check("m_data", bus.m_data, exp_q.pop_front());
            exp_words++;
          end
        end
        mon_prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
        mon_prev_data  = bus.m_data;
        mon_prev_epoch = rst_epoch;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.empty = 1'b1;
    bus.almost_empty = 1'b1;
    bus.dout = '0;
    bus.rd_ack = 1'b0;
    bus.rd_err = 1'b0;
    bus.m_ready = 1'b0;
    #1 rd_rst_n = 1'b0;
    #1;
    check("init_rd_en", bus.rd_en, 0);
    check("init_m_valid", bus.m_valid, 0);
    check("init_m_data", bus.m_data, 0);
    check("init_word_cnt", word_cnt, 0);
    check("init_err_cnt", err_cnt, 0);
    check("init_err_sticky", err_sticky, 0);
    check("init_busy", busy, 0);
    repeat (2) @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;

    // Full-rate burst of 8 words.
    for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(8'h11 + i));
    bus.m_ready = 1'b1;
    step();
    en = 1'b1;
    rd_pulses = 0;
    max_run = 0;
    wait_drain(60);
    check("burst_rd_pulses", rd_pulses, 8);
    check("burst_max_run", max_run, 8);
    check("burst_word_cnt", word_cnt, 8);
    check("burst_err_cnt", err_cnt, 0);

    // Same words with a stuttering consumer.
    for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(8'h11 + i));
    for (int i = 0; i < 80 && !(fifo_q.size() == 0 && exp_q.size() == 0 && occ_m == 0 && !rd_issued); i++) begin
      bus.m_ready = pat[i % 4];
      step();
    end
    bus.m_ready = 1'b1;
    wait_drain(20);
    check("stutter_word_cnt", word_cnt, 16);
    check("stutter_err_cnt", err_cnt, 0);

    // Single remaining word.
    rd_pulses = 0;
    fifo_q.push_back(8'h5A);
    run(10);
    check("single_rd_pulses", rd_pulses, 1);
    check("single_word_cnt", word_cnt, 17);

    // Read error: no push, word retried, error counted; then clear.
    rd_pulses = 0;
    err_mode_req = 1;
    fifo_q.push_back(8'h66);
    wait_drain(20);
    check("err_rd_pulses", rd_pulses, 2);
    check("err_word_cnt", word_cnt, 18);
    check("err_cnt_one", err_cnt, 1);
    check("err_sticky_set", err_sticky, 1);
    clr_req = 1;
    step();
    step();
    check("clr_err_cnt", err_cnt, 0);
    check("clr_err_sticky", err_sticky, 0);

    // Missing response and ack-with-err are both failures.
    err_mode_req = 2;
    fifo_q.push_back(8'h77);
    wait_drain(20);
    err_mode_req = 3;
    fifo_q.push_back(8'h78);
    wait_drain(20);
    check("err_modes_cnt", err_cnt, 2);
    check("err_modes_word_cnt", word_cnt, 20);

    // Error in the same cycle as clear leaves a single count.
    err_mode_req = 1;
    clr_on_err = 1;
    fifo_q.push_back(8'h79);
    wait_drain(20);
    check("clr_and_err_cnt", err_cnt, 1);
    check("clr_and_err_sticky", err_sticky, 1);

    // Responses with no read outstanding are ignored.
    spurious_en = 1;
    run(20);
    check("spurious_err_cnt", err_cnt, 1);
    check("spurious_word_cnt", word_cnt, 21);

    // Drop en in a cycle that issues a read.
    for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(8'hA0 + i));
    for (int i = 0; i < 10 && !rd_issued; i++) step();
    en = 1'b0;
    rd_pulses = 0;
    step();
    check("stop_busy_high", busy, 1);
    run(6);
    check("stop_rd_pulses", rd_pulses, 1);
    check("stop_busy_low", busy, 0);
    check("stop_word_cnt", word_cnt, 23);
    en = 1'b1;
    wait_drain(30);

    // Reset with a word buffered and a read in flight.
    en = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(8'hC0 + i));
    for (int i = 0; i < 10 && !(rd_issued && occ_m == 0); i++) step();
    en = 1'b0;
    rst_req = 1;
    step();
    bus.m_ready = 1'b1;
    run(5);
    check("post_rst_m_valid", bus.m_valid, 0);
    check("post_rst_word_cnt", word_cnt, 0);
    check("post_rst_err_cnt", err_cnt, 0);
    check("post_rst_busy", busy, 0);

    // Randomised traffic against the reference model.
    refill_en = 1;
    en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) err_mode_req = $urandom_range(1, 3);
      if ($urandom_range(0, 99) == 0) clr_req = 1;
      step();
    end
    refill_en = 0;
    en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(200);
    run(2);
    check("rand_word_cnt", word_cnt, exp_words);
    check("rand_err_cnt", err_cnt, exp_err);
    check("rand_err_sticky", err_sticky, exp_sticky);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
